// File: rtl/eight_bit_computer.sv
// rtl/eight_bit_computer.sv - two-register accumulator datapath with a shared tri-state bus
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-high reset (clears A, B and both flags)
//   bus            shared tri-state data bus (WIDTH bits)
//   reg1_data_in   load A from bus        reg1_data_out  drive A onto bus
//   reg1_clr       synchronous clear of A (wins over reg1_data_in)
//   reg2_data_in   load B from bus        reg2_data_out  drive B onto bus
//   reg2_clr       synchronous clear of B (wins over reg2_data_in)
//   alu_out        drive ALU result onto bus and capture flags
//   alu_sub        0 = A+B, 1 = A-B
//   reg1_q/reg2_q  contents of A and B
//   flag_c/flag_z  registered carry (no-borrow on subtract) and zero flags

module eight_bit_computer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    inout  wire  [WIDTH-1:0] bus,
    input  logic             reg1_data_in,
    input  logic             reg1_data_out,
    input  logic             reg1_clr,
    input  logic             reg2_data_in,
    input  logic             reg2_data_out,
    input  logic             reg2_clr,
    input  logic             alu_out,
    input  logic             alu_sub,
    output logic [WIDTH-1:0] reg1_q,
    output logic [WIDTH-1:0] reg2_q,
    output logic             flag_c,
    output logic             flag_z
);

    logic [WIDTH:0]   alu_sum;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic [WIDTH-1:0] drive_val;
    logic             drive_en;
    logic [WIDTH-1:0] load_val;

    // Subtraction is A + ~B + 1 so the carry out doubles as "no borrow".
    assign alu_sum    = {1'b0, reg1_q}
                      + {1'b0, (alu_sub ? ~reg2_q : reg2_q)}
                      + {{WIDTH{1'b0}}, alu_sub};
    assign alu_result = alu_sum[WIDTH-1:0];
    assign alu_carry  = alu_sum[WIDTH];

    // Fixed priority guarantees a single driver: A, then B, then the ALU.
    always_comb begin
        drive_en  = 1'b1;
        drive_val = alu_result;
        if (reg1_data_out) begin
            drive_val = reg1_q;
        end else if (reg2_data_out) begin
            drive_val = reg2_q;
        end else if (!alu_out) begin
            drive_en  = 1'b0;
            drive_val = '0;
        end
    end

    assign bus = drive_en ? drive_val : {WIDTH{1'bz}};

    // Internal sources are taken straight from the mux rather than the
    // resolved net; external sources come in through the bus.
    assign load_val = drive_en ? drive_val : bus;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg1_q <= '0;
            reg2_q <= '0;
            flag_c <= 1'b0;
            flag_z <= 1'b0;
        end else begin
            if (reg1_clr) begin
                reg1_q <= '0;
            end else if (reg1_data_in) begin
                reg1_q <= load_val;
            end

            if (reg2_clr) begin
                reg2_q <= '0;
            end else if (reg2_data_in) begin
                reg2_q <= load_val;
            end

            if (alu_out) begin
                flag_c <= alu_carry;
                flag_z <= (alu_result == '0);
            end
        end
    end

endmodule

// File: tb/tb_eight_bit_computer.sv
// tb/tb_eight_bit_computer.sv - self-checking bench for eight_bit_computer

module tb_eight_bit_computer;

    logic       clk = 1'b0;
    logic       reset;
    wire  [7:0] bus;
    logic       reg1_data_in, reg1_data_out, reg1_clr;
    logic       reg2_data_in, reg2_data_out, reg2_clr;
    logic       alu_out, alu_sub;
    logic [7:0] reg1_q, reg2_q;
    logic       flag_c, flag_z;

    logic       tb_en;
    logic [7:0] tb_val;

    // Pull-ups make an undriven bus read as 8'hff.
    assign bus = tb_en ? tb_val : 8'hzz;
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup pu (bus[i]);
    end

    eight_bit_computer #(.WIDTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .reg1_data_in  (reg1_data_in),
        .reg1_data_out (reg1_data_out),
        .reg1_clr      (reg1_clr),
        .reg2_data_in  (reg2_data_in),
        .reg2_data_out (reg2_data_out),
        .reg2_clr      (reg2_clr),
        .alu_out       (alu_out),
        .alu_sub       (alu_sub),
        .reg1_q        (reg1_q),
        .reg2_q        (reg2_q),
        .flag_c        (flag_c),
        .flag_z        (flag_z)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference state
    int ma, mb;
    bit mc, mz;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic void alu_model(input int a, input int b, input bit sub,
                                      output int r, output bit c);
        if (sub) begin
            r = (a - b + 256) % 256;
            c = (a >= b);
        end else begin
            r = (a + b) % 256;
            c = (a + b) > 255;
        end
    endfunction

    task automatic idle_ctl();
        reg1_data_in = 0; reg1_data_out = 0; reg1_clr = 0;
        reg2_data_in = 0; reg2_data_out = 0; reg2_clr = 0;
        alu_out = 0; alu_sub = 0; tb_en = 0; tb_val = 8'h00;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_reg(input bit which_b, input logic [7:0] v);
        idle_ctl();
        tb_en = 1; tb_val = v;
        if (which_b) reg2_data_in = 1; else reg1_data_in = 1;
        edge_step();
        if (which_b) mb = v; else ma = v;
        idle_ctl();
    endtask

    task automatic check_state(input string tag);
        check({tag, "_a"}, reg1_q, ma[7:0]);
        check({tag, "_b"}, reg2_q, mb[7:0]);
        check({tag, "_flags"}, {6'b0, flag_c, flag_z}, {6'b0, mc, mz});
    endtask

    initial begin
        int r;
        bit c;
        int v, na, nb;

        idle_ctl();
        reset = 1;
        #12;
        reset = 0;
        #1;
        ma = 0; mb = 0; mc = 0; mz = 0;
        check_state("reset");
        check("bus_idle", bus, 8'hff);

        // External load of A, then A drives the bus
        tb_en = 1; tb_val = 8'h2A; reg1_data_in = 1;
        edge_step();
        ma = 8'h2A;
        idle_ctl();
        reg1_data_out = 1;
        #1;
        check("ext_load_a", reg1_q, 8'h2A);
        check("a_on_bus", bus, 8'h2A);
        idle_ctl();

        // Accumulate: A = F0 + 20
        load_reg(0, 8'hF0);
        load_reg(1, 8'h20);
        alu_out = 1; reg1_data_in = 1;
        #1;
        check("add_bus", bus, 8'h10);
        edge_step();
        ma = 8'h10; mc = 1; mz = 0;
        check_state("accum");
        idle_ctl();

        // Subtract equal operands -> zero, no borrow
        load_reg(0, 8'h05);
        load_reg(1, 8'h05);
        alu_out = 1; alu_sub = 1;
        #1;
        check("sub_eq_bus", bus, 8'h00);
        edge_step();
        mc = 1; mz = 1;
        check_state("sub_eq");
        idle_ctl();

        // Subtract with borrow
        load_reg(0, 8'h03);
        alu_out = 1; alu_sub = 1;
        #1;
        check("sub_borrow_bus", bus, 8'hFE);
        edge_step();
        mc = 0; mz = 0;
        check_state("sub_borrow");
        idle_ctl();

        // Flags hold when alu_out is low
        edge_step();
        check_state("flag_hold");

        // Clear overrides load
        tb_en = 1; tb_val = 8'h77; reg1_data_in = 1; reg1_clr = 1;
        edge_step();
        ma = 0;
        check("clr_prio_a", reg1_q, 8'h00);
        idle_ctl();
        tb_en = 1; tb_val = 8'h66; reg2_data_in = 1; reg2_clr = 1;
        edge_step();
        mb = 0;
        check("clr_prio_b", reg2_q, 8'h00);
        idle_ctl();

        // A -> B transfer, B -> A transfer, self-transfer
        load_reg(0, 8'h33);
        reg1_data_out = 1; reg2_data_in = 1;
        edge_step();
        mb = 8'h33;
        check("a_to_b", reg2_q, 8'h33);
        idle_ctl();
        load_reg(1, 8'hC4);
        reg2_data_out = 1; reg1_data_in = 1;
        edge_step();
        ma = 8'hC4;
        check("b_to_a", reg1_q, 8'hC4);
        idle_ctl();
        reg1_data_out = 1; reg1_data_in = 1;
        edge_step();
        check("self_a", reg1_q, 8'hC4);
        idle_ctl();

        // Randomised sequences against the reference model
        for (int it = 0; it < 300; it++) begin
            idle_ctl();
            reg1_data_out = ($urandom_range(0, 3) == 0);
            reg2_data_out = ($urandom_range(0, 3) == 0);
            alu_out       = ($urandom_range(0, 2) == 0);
            alu_sub       = $urandom_range(0, 1);
            reg1_data_in  = $urandom_range(0, 1);
            reg2_data_in  = $urandom_range(0, 1);
            reg1_clr      = ($urandom_range(0, 7) == 0);
            reg2_clr      = ($urandom_range(0, 7) == 0);
            alu_model(ma, mb, alu_sub, r, c);
            if (reg1_data_out)      v = ma;
            else if (reg2_data_out) v = mb;
            else if (alu_out)       v = r;
            else begin
                v = $urandom_range(0, 255);
                tb_en = 1; tb_val = v[7:0];
            end
            #1;
            check("rnd_bus", bus, v[7:0]);
            na = reg1_clr ? 0 : (reg1_data_in ? v : ma);
            nb = reg2_clr ? 0 : (reg2_data_in ? v : mb);
            if (alu_out) begin
                mc = c;
                mz = (r == 0);
            end
            edge_step();
            ma = na; mb = nb;
            check_state("rnd");
        end
        idle_ctl();

        // Asynchronous reset between edges aborts a pending load
        load_reg(0, 8'h44);
        load_reg(1, 8'h55);
        tb_en = 1; tb_val = 8'h99; reg1_data_in = 1;
        @(negedge clk);
        reset = 1;
        #1;
        ma = 0; mb = 0; mc = 0; mz = 0;
        check_state("async_rst");
        tb_en = 0; reg1_data_out = 1;
        #1;
        check("rst_bus_a", bus, 8'h00);
        edge_step();
        check("rst_hold_a", reg1_q, 8'h00);
        @(negedge clk);
        reset = 0;
        idle_ctl();

        // First edge after reset behaves normally
        tb_en = 1; tb_val = 8'h5C; reg2_data_in = 1;
        edge_step();
        mb = 8'h5C;
        check_state("post_rst");
        idle_ctl();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/eight_bit_computer.md
EIGHT_BIT_COMPUTER -- requirements
Module: eight_bit_computer

Interface
REQ-001 Parameter WIDTH, default 8, data width of bus, registers and ALU; all requirements below are stated for WIDTH=8.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset is asynchronous and active-high.
REQ-004 bus  inout  8  shared tri-state data bus; driven only as defined in REQ-014, otherwise high-impedance.
REQ-005 reg1_data_in  input  1  load register A (reg1) from bus.
REQ-006 reg1_data_out  input  1  drive register A onto bus.
REQ-007 reg1_clr  input  1  synchronous clear of register A.
REQ-008 reg2_data_in  input  1  load register B (reg2) from bus.
REQ-009 reg2_data_out  input  1  drive register B onto bus.
REQ-010 reg2_clr  input  1  synchronous clear of register B.
REQ-011 alu_out  input  1  drive ALU result onto bus and capture flags.
REQ-012 alu_sub  input  1  ALU operation select: 0 = A+B, 1 = A-B.
REQ-013 reg1_q, reg2_q  output  8 each  current contents of A and B; flag_c, flag_z  output  1 each  registered carry and zero flags.

Function
REQ-014 Bus driver: reg1_data_out drives A; if reg1_data_out is low, reg2_data_out drives B; if both are low, alu_out drives the ALU result; if all three are low, bus = 8'hzz. Only one source drives at any time.
REQ-015 Register load: on the rising edge, reg1_data_in=1 loads A from the bus value present before the edge; reg2_data_in likewise loads B.
REQ-016 Clear priority: regN_clr=1 sets that register to 8'h00 on the rising edge and overrides regN_data_in in the same cycle.
REQ-017 Self-transfer: data_out and data_in asserted together on the same register leave its value unchanged; A->B and B->A transfers complete in one cycle.
REQ-018 Bus-to-load path is combinational: a register loaded from a source driven in the same cycle captures that source's value at the edge, with 1-cycle latency to reg1_q and reg2_q.
REQ-019 ALU is combinational on A and B: sum = A + B when alu_sub=0, A + ~B + 1 when alu_sub=1; result is 8 bits, wraps modulo 256.
REQ-020 Carry is the 9th bit of that addition; for subtraction, carry=1 means no borrow (A >= B).
REQ-021 On the rising edge with alu_out=1, flag_c takes the carry and flag_z takes (result == 0); when alu_out=0, the flags hold.
REQ-022 When the ALU drives the bus and also loads A (alu_out & reg1_data_in), A takes the result computed from the pre-edge A and B (accumulate).
REQ-023 Loading while the bus is undriven is a software error; the register value after such a load is unspecified and is not checked.

Reset
REQ-024 While reset=1, asynchronously and regardless of clk: A=8'h00, B=8'h00, flag_c=0, flag_z=0; all control inputs are ignored.
REQ-025 Bus drive follows REQ-014 combinationally during reset, so asserting reg1_data_out during reset puts 8'h00 on the bus.
REQ-026 Reset asserted mid-operation aborts any load in that cycle; the first edge after reset deassertion behaves normally.

Verification
REQ-027 Reset pulse, all controls 0 -> reg1_q=00, reg2_q=00, flags 00, bus=zz.
REQ-028 Bench drives bus=8'h2A with reg1_data_in=1 for one edge, then releases the bus and sets reg1_data_out=1 -> reg1_q=2A, bus=2A.
REQ-029 A=8'hF0, B=8'h20, alu_out=1, reg1_data_in=1, one edge -> reg1_q=10, flag_c=1, flag_z=0.
REQ-030 A=8'h05, B=8'h05, alu_sub=1, alu_out=1, one edge -> flag_z=1, flag_c=1, bus=00; with A=03, B=05 -> result FE, flag_c=0.
REQ-031 reg1_clr=1 and reg1_data_in=1 with bus=8'h77 -> reg1_q=00; reg1_data_out=1 and reg2_data_in=1 with A=33 -> reg2_q=33 after one edge.
REQ-032 reset asserted between edges while reg1_data_in=1 -> reg1_q=00 immediately, without waiting for clk.
